fdivsqrt_sched: RTL and testbench

Sequencing controller and two-way arbiter for the shared divide/square-root unit. It grants the unit to either the FP div/sqrt requester or the integer divide requester. It pulses the preprocessing load strobe and drives the integer/FP operand select. It counts the iteration cycles reported by the preprocessor and holds the result-valid indication until the consumer accepts it. It sits between the FPU/MDU issue logic and the preprocessing/iteration datapath.

---
 rtl/fdivsqrt_sched.sv | 125 ++++++++++++
 tb/tb_fdivsqrt_sched.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fdivsqrt_sched.sv
// rtl/fdivsqrt_sched.sv - grant/sequencing controller for the shared divide/sqrt unit
module fdivsqrt_sched #(
    parameter int DURLEN = 7
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fp_req,
    input  logic              int_req,
    input  logic [DURLEN-1:0] cycles_e,
    input  logic              special_e,
    input  logic              flush,
    input  logic              stall,
    output logic              start,
    output logic              fp_grant,
    output logic              int_grant,
    output logic              int_sel,
    output logic              owner_int,
    output logic              iter_en,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT             state, stateNext;
    logic [DURLEN-1:0] count, countNext;
    logic              ptrInt, ptrIntNext;
    logic              ownerInt, ownerIntNext;
    logic              coolDown, coolDownNext;
    logic              grantFp, grantInt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            count    <= '0;
            ptrInt   <= 1'b0;
            ownerInt <= 1'b0;
            coolDown <= 1'b0;
        end else begin
            state    <= stateNext;
            count    <= countNext;
            ptrInt   <= ptrIntNext;
            ownerInt <= ownerIntNext;
            coolDown <= coolDownNext;
        end
    end

    always_comb begin
        stateNext    = state;
        countNext    = count;
        ptrIntNext   = ptrInt;
        ownerIntNext = ownerInt;
        coolDownNext = 1'b0;
        grantFp      = 1'b0;
        grantInt     = 1'b0;
        iter_en      = 1'b0;
        done         = 1'b0;

        case (state)
            IDLE: begin
                // coolDown blocks the first IDLE cycle after a completed result
                if (!flush && !coolDown) begin
                    if (fp_req && (!int_req || !ptrInt)) begin
                        grantFp = 1'b1;
                    end else if (int_req) begin
                        grantInt = 1'b1;
                    end
                    if (grantFp || grantInt) begin
                        ownerIntNext = grantInt;
                        ptrIntNext   = grantFp;
                        if (special_e || (cycles_e == '0)) begin
                            stateNext = DONE;
                            countNext = '0;
                        end else begin
                            stateNext = BUSY;
                            countNext = cycles_e;
                        end
                    end
                end
            end
            BUSY: begin
                if (flush) begin
                    stateNext = IDLE;
                    countNext = '0;
                end else begin
                    iter_en = 1'b1;
                    if (count <= DURLEN'(1)) begin
                        stateNext = DONE;
                        countNext = '0;
                    end else begin
                        countNext = count - DURLEN'(1);
                    end
                end
            end
            DONE: begin
                if (flush) begin
                    stateNext = IDLE;
                    countNext = '0;
                end else begin
                    done = 1'b1;
                    if (!stall) begin
                        stateNext    = IDLE;
                        coolDownNext = 1'b1;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
                countNext = '0;
            end
        endcase
    end

    assign start     = grantFp | grantInt;
    assign fp_grant  = grantFp;
    assign int_grant = grantInt;
    assign int_sel   = grantInt;
    assign owner_int = ownerInt;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_fdivsqrt_sched.sv
// tb/tb_fdivsqrt_sched.sv - directed bench with a cycle-level behavioural model of fdivsqrt_sched
module tb_fdivsqrt_sched;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       fp_req = 1'b0, int_req = 1'b0, special_e = 1'b0, flush = 1'b0, stall = 1'b0;
    logic [6:0] cycles_e = '0;
    logic       start, fp_grant, int_grant, int_sel, owner_int, iter_en, busy, done;

    fdivsqrt_sched #(.DURLEN(7)) dut (
        .clk(clk), .reset_n(reset_n), .fp_req(fp_req), .int_req(int_req),
        .cycles_e(cycles_e), .special_e(special_e), .flush(flush), .stall(stall),
        .start(start), .fp_grant(fp_grant), .int_grant(int_grant), .int_sel(int_sel),
        .owner_int(owner_int), .iter_en(iter_en), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: remaining iterations, result pending, one-cycle holdoff after a result is taken
    int   mIters = 0;
    logic mDone = 0, mHold = 0, mPtrInt = 0, mOwner = 0;
    logic eIdle, canG, eFp, eInt;

    int   iterCount = 0, doneCount = 0, firstDoneCyc = -1, lastGrantCyc = -1, lastGrantInt = -1;
    logic prevDone = 0;
    int   gCyc[$];
    int   gInt[$];

    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_start", start, 0);
            chk("rst_grants", {fp_grant, int_grant, int_sel}, 0);
            chk("rst_iter_en", iter_en, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_owner", owner_int, 0);
            mIters = 0; mDone = 0; mHold = 0; mPtrInt = 0; mOwner = 0; prevDone = 0;
        end else begin
            eIdle = (mIters == 0) && !mDone;
            canG  = eIdle && !mHold && !flush;
            eFp   = canG && fp_req && (!int_req || !mPtrInt);
            eInt  = canG && int_req && !eFp;

            chk("fp_grant", fp_grant, eFp);
            chk("int_grant", int_grant, eInt);
            chk("start", start, eFp | eInt);
            chk("int_sel", int_sel, eInt);
            chk("iter_en", iter_en, (mIters > 0) && !flush);
            chk("done", done, mDone && !flush);
            chk("busy", busy, !eIdle);
            chk("owner_int", owner_int, mOwner);

            if (fp_grant || int_grant) begin
                lastGrantCyc = cyc;
                lastGrantInt = int_grant;
                gCyc.push_back(cyc);
                gInt.push_back(int_grant);
            end
            if (iter_en) iterCount++;
            if (done) doneCount++;
            if (done && !prevDone) firstDoneCyc = cyc;
            prevDone = done;

            if (flush) begin
                mIters = 0; mDone = 0; mHold = 0;
            end else if (eFp || eInt) begin
                mOwner  = eInt;
                mPtrInt = eFp;
                mHold   = 0;
                if (special_e || cycles_e == 0) mDone = 1;
                else mIters = cycles_e;
            end else if (mIters > 0) begin
                mIters--;
                if (mIters == 0) mDone = 1;
            end else if (mDone) begin
                if (!stall) begin
                    mDone = 0;
                    mHold = 1;
                end
            end else begin
                mHold = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int g, b, d0, i0;

    initial begin
        tick(2);
        chk("lit_reset_busy", busy, 0);
        chk("lit_reset_start", start, 0);
        reset_n = 1'b1;
        tick(1);

        // both requests continuously, 3 iterations each: fp,int,fp,int every 6 cycles
        g = cyc; b = gCyc.size();
        fp_req = 1; int_req = 1; cycles_e = 3;
        tick(19);
        fp_req = 0; int_req = 0;
        tick(6);
        chk("alt_count", gCyc.size() - b, 4);
        if (gCyc.size() >= b + 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("alt_cycle", gCyc[b+i] - g, i * 6);
                chk("alt_who", gInt[b+i], i % 2);
            end
        end

        // FP alone, 5 iterations
        g = cyc; i0 = iterCount; d0 = doneCount;
        fp_req = 1; cycles_e = 5;
        tick(1);
        fp_req = 0;
        tick(8);
        chk("fp5_grant_cyc", lastGrantCyc - g, 0);
        chk("fp5_grant_who", lastGrantInt, 0);
        chk("fp5_iters", iterCount - i0, 5);
        chk("fp5_done_cyc", firstDoneCyc - g, 6);
        chk("fp5_done_len", doneCount - d0, 1);
        chk("fp5_owner", owner_int, 0);

        // special int op then an FP request waiting behind it
        g = cyc; i0 = iterCount; d0 = doneCount;
        int_req = 1; special_e = 1; cycles_e = 20;
        tick(1);
        int_req = 0; special_e = 0; fp_req = 1; cycles_e = 2;
        tick(2);
        chk("spec_no_iter", iterCount - i0, 0);
        chk("spec_done_cyc", firstDoneCyc - g, 1);
        chk("spec_done_len", doneCount - d0, 1);
        tick(1);
        fp_req = 0;
        chk("spec_next_grant", lastGrantCyc - g, 3);
        chk("spec_next_who", lastGrantInt, 0);
        tick(5);

        // stall holds DONE for 3 extra cycles, pending int waits until after DONE
        g = cyc; d0 = doneCount;
        fp_req = 1; cycles_e = 4;
        tick(1);
        fp_req = 0; stall = 1;
        tick(4);
        int_req = 1;
        tick(3);
        stall = 0;
        tick(3);
        chk("stall_done_len", doneCount - d0, 4);
        chk("stall_done_cyc", firstDoneCyc - g, 5);
        chk("stall_next_grant", lastGrantCyc - g, 10);
        chk("stall_next_who", lastGrantInt, 1);
        int_req = 0;
        tick(7);

        // flush in BUSY cycle 2; pending int granted once flush drops
        g = cyc; d0 = doneCount; i0 = iterCount;
        fp_req = 1; cycles_e = 8;
        tick(1);
        fp_req = 0; int_req = 1;
        tick(1);
        flush = 1;
        tick(2);
        flush = 0;
        chk("flush_no_done", doneCount - d0, 0);
        chk("flush_iters", iterCount - i0, 1);
        tick(1);
        int_req = 0;
        chk("flush_grant_cyc", lastGrantCyc - g, 4);
        chk("flush_grant_who", lastGrantInt, 1);
        tick(11);
        chk("flush_done_total", doneCount - d0, 1);
        chk("flush_done_cyc", firstDoneCyc - g, 13);

        // reset in the middle of a 10-iteration FP op
        g = cyc; d0 = doneCount;
        fp_req = 1; cycles_e = 10;
        tick(1);
        fp_req = 0;
        tick(3);
        reset_n = 0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_iter", iter_en, 0);
        chk("midrst_done", done, 0);
        tick(1);
        reset_n = 1;
        chk("midrst_no_done", doneCount - d0, 0);
        fp_req = 1; int_req = 1; cycles_e = 1;
        #1;
        chk("midrst_ptr_fp", fp_grant, 1);
        chk("midrst_ptr_int", int_grant, 0);
        tick(1);
        fp_req = 0; int_req = 0;
        tick(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
